// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared helpers and lane state type for the lane array scheduler
package sched_pkg;

  typedef enum logic {
    LANE_FREE = 1'b0,
    LANE_BUSY = 1'b1
  } lane_state_t;

  // Ceiling log2, never below 1 so single-entry ids still get a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // 32-bit one-hot of a bit index; callers size-cast down to their vector width.
  function automatic logic [31:0] onehot(input int b);
    return 32'h1 << b;
  endfunction

endpackage

// File: rtl/lane_array_sched_lane_tracker.sv
// rtl/lane_array_sched_lane_tracker.sv - per-lane busy FSM with hold counter and timeout pulse
module lane_tracker
  import sched_pkg::*;
#(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = clog2(HOLD_MAX + 1)
) (
  input  logic clock,
  input  logic reset_n,
  input  logic grant,
  input  logic done,
  output logic busy,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  lane_state_t state;
  logic [CNT_W-1:0] cnt;
  logic hold_hit;

  // The counter holds the number of completed busy cycles, so it equals
  // HOLD_MAX-1 during the last allowed busy cycle.
  assign busy        = (state == LANE_BUSY);
  assign hold_hit    = busy && (cnt == CNT_LAST);
  assign timeout_err = hold_hit && !done;

  // Lane occupancy: grant claims the lane, done or hold expiry releases it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= LANE_FREE;
      cnt   <= '0;
    end else if (grant) begin
      state <= LANE_BUSY;
      cnt   <= '0;
    end else if (state == LANE_BUSY) begin
      if (done || hold_hit) begin
        state <= LANE_FREE;
      end else if (cnt != CNT_SAT) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lane_array_sched.sv
// rtl/lane_array_sched.sv - round-robin binder of requesters onto a shared array of worker lanes
module lane_array_sched
  import sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_LANES = 4,
  parameter int HOLD_MAX  = 15,
  parameter int REQ_W     = clog2(NUM_REQ),
  parameter int LANE_W    = clog2(NUM_LANES)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   req_ack,
  input  logic [NUM_LANES-1:0] done,
  output logic                 gnt_valid,
  output logic [REQ_W-1:0]     gnt_req_id,
  output logic [LANE_W-1:0]    gnt_lane_id,
  output logic [NUM_LANES-1:0] gnt_lane_onehot,
  output logic [NUM_LANES-1:0] lane_busy,
  output logic [NUM_LANES-1:0] timeout_err
);

  logic [REQ_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]   elig;
  logic                 win_found;
  logic [REQ_W-1:0]     win_id;
  logic                 lane_found;
  logic [LANE_W-1:0]    lane_id;
  logic                 issue;
  logic [NUM_LANES-1:0] lane_sel;
  logic [NUM_REQ-1:0]   req_sel;
  logic [NUM_LANES-1:0] lane_grant;
  logic [REQ_W-1:0]     rr_next;
  int                   idx;
  int                   nxt;

  // The requester acked last cycle may still hold req; mask it to avoid a double grant.
  assign elig = req & ~req_ack;

  // Round-robin pick: first eligible requester at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (elig[idx]) begin
        win_found = 1'b1;
        win_id    = idx[REQ_W-1:0];
      end
    end
  end

  // Free-lane priority encoder: lowest-index lane not busy before this edge.
  always_comb begin
    lane_found = 1'b0;
    lane_id    = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (!lane_busy[i]) begin
        lane_found = 1'b1;
        lane_id    = i[LANE_W-1:0];
      end
    end
  end

  assign issue      = win_found && lane_found;
  assign lane_sel   = NUM_LANES'(onehot(int'(lane_id)));
  assign req_sel    = NUM_REQ'(onehot(int'(win_id)));
  assign lane_grant = issue ? lane_sel : '0;
  assign nxt        = (int'(win_id) + 1) % NUM_REQ;
  assign rr_next    = nxt[REQ_W-1:0];

  // Grant registers: pulse outputs each issue, ids hold between grants.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_valid       <= 1'b0;
      req_ack         <= '0;
      gnt_req_id      <= '0;
      gnt_lane_id     <= '0;
      gnt_lane_onehot <= '0;
      rr_ptr          <= '0;
    end else if (issue) begin
      gnt_valid       <= 1'b1;
      req_ack         <= req_sel;
      gnt_req_id      <= win_id;
      gnt_lane_id     <= lane_id;
      gnt_lane_onehot <= lane_sel;
      rr_ptr          <= rr_next;
    end else begin
      gnt_valid       <= 1'b0;
      req_ack         <= '0;
      gnt_lane_onehot <= '0;
    end
  end

  lane_tracker #(
    .HOLD_MAX(HOLD_MAX)
  ) trk [NUM_LANES-1:0] (
    .clock      (clock),
    .reset_n    (reset_n),
    .grant      (lane_grant),
    .done       (done),
    .busy       (lane_busy),
    .timeout_err(timeout_err)
  );

endmodule

// File: tb/tb_lane_array_sched.sv
// tb/tb_lane_array_sched.sv - self-checking bench for lane_array_sched
module tb_lane_array_sched;

  localparam int NR = 4;
  localparam int NL = 4;
  localparam int HM = 15;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [NL-1:0] done = '0;
  logic [NR-1:0] req_ack;
  logic          gnt_valid;
  logic [1:0]    gnt_req_id;
  logic [1:0]    gnt_lane_id;
  logic [NL-1:0] gnt_lane_onehot;
  logic [NL-1:0] lane_busy;
  logic [NL-1:0] timeout_err;

  int n_vec = 0;
  int n_err = 0;

  lane_array_sched #(
    .NUM_REQ  (NR),
    .NUM_LANES(NL),
    .HOLD_MAX (HM)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .req            (req),
    .req_ack        (req_ack),
    .done           (done),
    .gnt_valid      (gnt_valid),
    .gnt_req_id     (gnt_req_id),
    .gnt_lane_id    (gnt_lane_id),
    .gnt_lane_onehot(gnt_lane_onehot),
    .lane_busy      (lane_busy),
    .timeout_err    (timeout_err)
  );

  always #5 clock = ~clock;

  // Reference model: lane occupancy as "which busy cycle is this" (1-based).
  int        m_rr;
  bit        m_busy [NL];
  int        m_cyc  [NL];
  logic [NR-1:0] m_ack;
  logic [NL-1:0] m_oh;
  bit        m_valid;
  int        m_rid;
  int        m_lid;

  typedef struct {
    logic [NR-1:0] req;
    logic [NL-1:0] done;
    logic          valid;
    logic [NR-1:0] ack;
    int            rid;
    int            lid;
    logic [NL-1:0] oh;
    logic [NL-1:0] busy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rr = 0; m_ack = '0; m_oh = '0; m_valid = 0; m_rid = 0; m_lid = 0;
    for (int i = 0; i < NL; i++) begin
      m_busy[i] = 0;
      m_cyc[i]  = 0;
    end
  endfunction

  function automatic void model_update(input logic [NR-1:0] r, input logic [NL-1:0] d);
    logic [NR-1:0] el;
    int w;
    int l;
    el = r & ~m_ack;
    w = -1;
    l = -1;
    for (int k = 0; k < NR; k++)
      if (w < 0 && el[(m_rr + k) % NR]) w = (m_rr + k) % NR;
    for (int i = 0; i < NL; i++)
      if (l < 0 && !m_busy[i]) l = i;
    for (int i = 0; i < NL; i++) begin
      if (m_busy[i]) begin
        if (d[i] || m_cyc[i] == HM) m_busy[i] = 0;
        else m_cyc[i]++;
      end
    end
    if (w >= 0 && l >= 0) begin
      m_busy[l] = 1;
      m_cyc[l]  = 1;
      m_valid   = 1;
      m_ack     = NR'(1 << w);
      m_oh      = NL'(1 << l);
      m_rid     = w;
      m_lid     = l;
      m_rr      = (w + 1) % NR;
    end else begin
      m_valid = 0;
      m_ack   = '0;
      m_oh    = '0;
    end
  endfunction

  function automatic logic [NL-1:0] model_busy_mask();
    logic [NL-1:0] b;
    for (int i = 0; i < NL; i++) b[i] = m_busy[i];
    return b;
  endfunction

  task automatic reset_dut();
    reset_n = 1'b0;
    req = '0;
    done = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // Apply inputs mid-cycle, check the combinational timeout, then take one edge.
  task automatic drive_edge(input logic [NR-1:0] r, input logic [NL-1:0] d);
    logic [NL-1:0] exp_to;
    req = r;
    done = d;
    #1;
    exp_to = '0;
    for (int i = 0; i < NL; i++)
      if (m_busy[i] && m_cyc[i] == HM && !d[i]) exp_to[i] = 1'b1;
    chk("timeout_err", 32'(timeout_err), 32'(exp_to));
    @(posedge clock);
    model_update(r, d);
    #1;
  endtask

  task automatic chk_model();
    chk("m_gnt_valid", 32'(gnt_valid), 32'(m_valid));
    chk("m_req_ack", 32'(req_ack), 32'(m_ack));
    chk("m_gnt_req_id", 32'(gnt_req_id), 32'(m_rid));
    chk("m_gnt_lane_id", 32'(gnt_lane_id), 32'(m_lid));
    chk("m_onehot", 32'(gnt_lane_onehot), 32'(m_oh));
    chk("m_lane_busy", 32'(lane_busy), 32'(model_busy_mask()));
  endtask

  initial begin
    logic [NR-1:0] cur;
    logic [NL-1:0] d;

    //            req      done     vld  ack      rid lid oh       busy
    tbl[0]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2, 0, 4'b0001, 4'b0001};
    tbl[1]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 2, 0, 4'b0000, 4'b0001};
    tbl[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 3, 1, 4'b0010, 4'b0011};
    tbl[3]  = '{4'b0111, 4'b0000, 1'b1, 4'b0001, 0, 2, 4'b0100, 4'b0111};
    tbl[4]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1, 3, 4'b1000, 4'b1111};
    tbl[5]  = '{4'b0100, 4'b0000, 1'b0, 4'b0000, 1, 3, 4'b0000, 4'b1111};
    tbl[6]  = '{4'b0100, 4'b0100, 1'b0, 4'b0000, 1, 3, 4'b0000, 4'b1011};
    tbl[7]  = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 2, 2, 4'b0100, 4'b1111};
    tbl[8]  = '{4'b0000, 4'b1111, 1'b0, 4'b0000, 2, 2, 4'b0000, 4'b0000};
    tbl[9]  = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 3, 0, 4'b0001, 4'b0001};
    tbl[10] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 0, 1, 4'b0010, 4'b0011};
    tbl[11] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 3, 2, 4'b0100, 4'b0111};
    tbl[12] = '{4'b0000, 4'b0111, 1'b0, 4'b0000, 3, 2, 4'b0000, 4'b0000};

    // Reset state
    reset_dut();
    chk("rst_gnt_valid", 32'(gnt_valid), 0);
    chk("rst_req_ack", 32'(req_ack), 0);
    chk("rst_lane_busy", 32'(lane_busy), 0);
    chk("rst_onehot", 32'(gnt_lane_onehot), 0);

    // Directed table: single request, fill, full+done, round-robin wrap
    for (int v = 0; v < 13; v++) begin
      drive_edge(tbl[v].req, tbl[v].done);
      chk($sformatf("t%0d_gnt_valid", v), 32'(gnt_valid), 32'(tbl[v].valid));
      chk($sformatf("t%0d_req_ack", v), 32'(req_ack), 32'(tbl[v].ack));
      chk($sformatf("t%0d_gnt_req_id", v), 32'(gnt_req_id), 32'(tbl[v].rid));
      chk($sformatf("t%0d_gnt_lane_id", v), 32'(gnt_lane_id), 32'(tbl[v].lid));
      chk($sformatf("t%0d_onehot", v), 32'(gnt_lane_onehot), 32'(tbl[v].oh));
      chk($sformatf("t%0d_lane_busy", v), 32'(lane_busy), 32'(tbl[v].busy));
    end

    // Async reset while lanes 0,1 busy and a grant is showing
    reset_dut();
    drive_edge(4'b0011, 4'b0000);
    drive_edge(4'b0010, 4'b0000);
    chk("pre_rst_gnt_valid", 32'(gnt_valid), 1);
    chk("pre_rst_lane_busy", 32'(lane_busy), 32'h3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_gnt_valid", 32'(gnt_valid), 0);
    chk("async_req_ack", 32'(req_ack), 0);
    chk("async_req_id", 32'(gnt_req_id), 0);
    chk("async_lane_id", 32'(gnt_lane_id), 0);
    chk("async_onehot", 32'(gnt_lane_onehot), 0);
    chk("async_lane_busy", 32'(lane_busy), 0);
    chk("async_timeout", 32'(timeout_err), 0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    req = '0;
    for (int c = 0; c < 3; c++) begin
      drive_edge(4'b0000, 4'b0000);
      chk("post_rst_gnt_valid", 32'(gnt_valid), 0);
      chk("post_rst_lane_busy", 32'(lane_busy), 0);
    end

    // Timeout: lane 0 held with no done, pulse on the 15th busy cycle only
    reset_dut();
    drive_edge(4'b0001, 4'b0000);
    chk("to_grant_busy", 32'(lane_busy), 32'h1);
    for (int c = 1; c <= HM; c++) begin
      req = '0;
      done = '0;
      #1;
      chk($sformatf("to_pulse_c%0d", c), 32'(timeout_err), (c == HM) ? 32'h1 : 32'h0);
      chk($sformatf("to_busy_c%0d", c), 32'(lane_busy[0]), 1);
      @(posedge clock);
      model_update('0, '0);
      #1;
    end
    chk("to_released", 32'(lane_busy), 0);
    chk("to_after", 32'(timeout_err), 0);

    // done on the expiry edge takes priority: no error, lane still released
    drive_edge(4'b0001, 4'b0000);
    for (int c = 1; c < HM; c++) drive_edge(4'b0000, 4'b0000);
    req = '0;
    done = 4'b0001;
    #1;
    chk("done_vs_to_err", 32'(timeout_err), 0);
    @(posedge clock);
    model_update('0, 4'b0001);
    #1;
    chk("done_vs_to_busy", 32'(lane_busy), 0);

    // done on a free lane is ignored
    drive_edge(4'b0000, 4'b1111);
    chk("done_free_busy", 32'(lane_busy), 0);
    chk("done_free_valid", 32'(gnt_valid), 0);

    // Randomized traffic against the model; requesters hold until acked
    reset_dut();
    cur = '0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 19) == 0) cur &= NR'($urandom);
      cur |= NR'($urandom) & NR'($urandom);
      if (c < 1000) begin
        d = NL'($urandom) & NL'($urandom) & NL'($urandom);
      end else begin
        d = '0;
        for (int i = 0; i < NL; i++) d[i] = ($urandom_range(0, 31) == 0);
      end
      drive_edge(cur, d);
      chk_model();
      cur &= ~m_ack;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
